// File: rtl/fetch_unit.sv
// Instruction fetch front end: 1-cycle synchronous memory, 2-entry decode queue, redirect flush.
// Optional halt detection (HALT_PEND/HALTED states, halted output) is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter int                     addr_width  = 9,
  parameter int                     instr_width = 9,
  parameter logic [addr_width-1:0]  start_addr  = '0,
  parameter logic [instr_width-1:0] halt_opcode = 9'h1FF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [addr_width-1:0]  instr_pc,
  input  logic [instr_width-1:0] instr_in,
  input  logic                   branch_en,
  input  logic [addr_width-1:0]  branch_target,
  output logic                   instr_valid,
  output logic [instr_width-1:0] instr_out,
  output logic [addr_width-1:0]  instr_out_pc,
  input  logic                   dec_ready,
  output logic                   halted
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t                 state;
  logic [addr_width-1:0]  pc;
  logic                   req_valid_q;
  logic [addr_width-1:0]  req_pc_q;
  logic [1:0]             count;
  logic [instr_width-1:0] dat0, dat1;
  logic [addr_width-1:0]  pc0, pc1;

  logic       pop, push, halt_hit, issue;
  logic [2:0] occupancy;
  logic [1:0] wr_slot;

  assign instr_pc     = pc;
  assign instr_valid  = (count != 2'd0) && (state != HALTED);
  assign instr_out    = dat0;
  assign instr_out_pc = pc0;

  assign pop  = instr_valid & dec_ready;
  // Words returning outside RUN belong to requests behind a halt and are dropped.
  assign push = req_valid_q && (state == RUN);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = push && (instr_in == halt_opcode);
`else
  assign halt_hit = 1'b0;
`endif

  // Credit: queued words plus the one in flight must leave room after this cycle's pop.
  assign occupancy = {1'b0, count} + {2'b00, req_valid_q};
  assign issue     = (state == RUN) && !branch_en && !halt_hit &&
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign wr_slot   = count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= start_addr;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      count       <= 2'd0;
      dat0        <= '0;
      dat1        <= '0;
      pc0         <= '0;
      pc1         <= '0;
      halted      <= 1'b0;
    end else if (state == HALTED) begin
      req_valid_q <= 1'b0;
    end else if (branch_en) begin
      count       <= 2'd0;
      req_valid_q <= 1'b0;
      pc          <= branch_target;
      state       <= RUN;
    end else begin
      if (pop) begin
        dat0 <= dat1;
        pc0  <= pc1;
      end
      if (push) begin
        if (wr_slot == 2'd0) begin
          dat0 <= instr_in;
          pc0  <= req_pc_q;
        end else begin
          dat1 <= instr_in;
          pc1  <= req_pc_q;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};

      req_valid_q <= issue;
      if (issue) begin
        req_pc_q <= pc;
        pc       <= pc + 1'b1;
      end

      // Once halted is pending nothing is pushed, so the halt word is the last entry.
      if (halt_hit) begin
        state <= HALT_PEND;
      end else if ((state == HALT_PEND) && pop && (count == 2'd1)) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

endmodule
